// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one three-operand adder. A round-robin
// arbiter picks one request per cycle; the exact sum is captured in a one-entry
// output register, tagged with the requester id, and drained via valid/ready.
module adder_arbiter #(
    parameter int unsigned width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               req0_v_i,
    input  logic [width_p-1:0] req0_a_i,
    input  logic [width_p-1:0] req0_b_i,
    input  logic [width_p-1:0] req0_c_i,
    output logic               req0_ready_o,
    input  logic               req1_v_i,
    input  logic [width_p-1:0] req1_a_i,
    input  logic [width_p-1:0] req1_b_i,
    input  logic [width_p-1:0] req1_c_i,
    output logic               req1_ready_o,
    output logic               sum_v_o,
    output logic [width_p+1:0] sum_o,
    output logic               sum_id_o,
    input  logic               sum_ready_i
);

    localparam int unsigned SumW = width_p + 2;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            r_state;
    logic              r_last_grant;
    logic [SumW-1:0]   r_sum;
    logic              r_sum_id;

    logic              w_can_accept;
    logic              w_gnt_v;
    logic              w_gnt_id;
    logic              w_xfer;
    logic [width_p-1:0] w_a;
    logic [width_p-1:0] w_b;
    logic [width_p-1:0] w_c;
    logic [SumW-1:0]   w_sum;

    // Round-robin grant: on contention the requester that did not win last goes.
    always_comb begin
        w_gnt_v  = req0_v_i | req1_v_i;
        w_gnt_id = 1'b0;
        if (req0_v_i && req1_v_i) begin
            w_gnt_id = ~r_last_grant;
        end else if (req1_v_i) begin
            w_gnt_id = 1'b1;
        end
    end

    // A full register can take a new sum in the same cycle it is drained.
    assign w_can_accept = (r_state == StEmpty) || sum_ready_i;
    assign w_xfer       = w_gnt_v && w_can_accept;

    assign req0_ready_o = w_gnt_v && !w_gnt_id && w_can_accept;
    assign req1_ready_o = w_gnt_v &&  w_gnt_id && w_can_accept;

    // Operand mux feeding the single shared adder; widened so nothing is lost.
    always_comb begin
        w_a   = w_gnt_id ? req1_a_i : req0_a_i;
        w_b   = w_gnt_id ? req1_b_i : req0_b_i;
        w_c   = w_gnt_id ? req1_c_i : req0_c_i;
        w_sum = {2'b00, w_a} + {2'b00, w_b} + {2'b00, w_c};
    end

    // Output FSM with result register; last_grant moves only on an accepted transfer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= StEmpty;
            r_last_grant <= 1'b1;
            r_sum        <= '0;
            r_sum_id     <= 1'b0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_xfer) begin
                        r_state      <= StFull;
                        r_sum        <= w_sum;
                        r_sum_id     <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                    end
                end
                StFull: begin
                    if (w_xfer) begin
                        r_sum        <= w_sum;
                        r_sum_id     <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                    end else if (sum_ready_i) begin
                        r_state <= StEmpty;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    assign sum_v_o  = (r_state == StFull);
    assign sum_o    = r_sum;
    assign sum_id_o = r_sum_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a cycle table for arbitration and
// backpressure, an exhaustive operand sweep per port, and async reset checks.
// Results are checked against a scoreboard queue filled at each accepted request.
module tb_adder_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned SW = W + 2;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          req0_v_i, req1_v_i;
    logic [W-1:0]  req0_a_i, req0_b_i, req0_c_i;
    logic [W-1:0]  req1_a_i, req1_b_i, req1_c_i;
    logic          req0_ready_o, req1_ready_o;
    logic          sum_v_o;
    logic [SW-1:0] sum_o;
    logic          sum_id_o;
    logic          sum_ready_i;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          id;
    } exp_t;

    typedef struct {
        logic         v0;
        logic [W-1:0] a0, b0, c0;
        logic         v1;
        logic [W-1:0] a1, b1, c1;
        logic         srdy;
        logic         r0, r1;
    } vec_t;

    exp_t q[$];
    vec_t tbl[11];
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    adder_arbiter #(.width_p(W)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .req0_v_i     (req0_v_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_c_i     (req0_c_i),
        .req0_ready_o (req0_ready_o),
        .req1_v_i     (req1_v_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_c_i     (req1_c_i),
        .req1_ready_o (req1_ready_o),
        .sum_v_o      (sum_v_o),
        .sum_o        (sum_o),
        .sum_id_o     (sum_id_o),
        .sum_ready_i  (sum_ready_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic [W-1:0] c0, input logic v1, input logic [W-1:0] a1,
                                input logic [W-1:0] b1, input logic [W-1:0] c1,
                                input logic srdy, input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.srdy = srdy; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    function automatic logic [SW-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return SW'(s);
    endfunction

    task automatic drive(input vec_t v);
        req0_v_i = v.v0; req0_a_i = v.a0; req0_b_i = v.b0; req0_c_i = v.c0;
        req1_v_i = v.v1; req1_a_i = v.a1; req1_b_i = v.b1; req1_c_i = v.c1;
        sum_ready_i = v.srdy;
    endtask

    // Scoreboard step at the falling edge: compare/drain the held result, then
    // record any request accepted at the coming rising edge.
    task automatic cycle_check();
        @(negedge clk_i);
        check("sum_v", 32'(sum_v_o), 32'(q.size() != 0));
        if (sum_v_o && q.size() != 0) begin
            check("sum", 32'(sum_o), 32'(q[0].sum));
            check("sum_id", 32'(sum_id_o), 32'(q[0].id));
            if (sum_ready_i) void'(q.pop_front());
        end
        if (req0_v_i && req0_ready_o)
            q.push_back(exp_t'{sum: ref_sum(req0_a_i, req0_b_i, req0_c_i), id: 1'b0});
        if (req1_v_i && req1_ready_o)
            q.push_back(exp_t'{sum: ref_sum(req1_a_i, req1_b_i, req1_c_i), id: 1'b1});
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        drive(v);
        #1;
        check({tag, ".ready0"}, 32'(req0_ready_o), 32'(v.r0));
        check({tag, ".ready1"}, 32'(req1_ready_o), 32'(v.r1));
        cycle_check();
    endtask

    initial begin
        // Contention from reset: grants 0,1,0,1, then backpressure with sum 15 held.
        tbl[0]  = mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2,  4'd4,  4'd6,  1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2,  4'd4,  4'd6,  1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2,  4'd4,  4'd6,  1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2,  4'd4,  4'd6,  1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 1'b0);

        drive(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        reset_n_i = 1'b0;
        #2;
        check("reset.sum_v", 32'(sum_v_o), 32'd0);
        check("reset.sum", 32'(sum_o), 32'd0);
        check("reset.sum_id", 32'(sum_id_o), 32'd0);
        #10;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 11; i++) begin
            apply_vec(tbl[i], $sformatf("tbl%0d", i));
            // During the stall the held 15 must not move.
            if (i >= 5 && i <= 7) check("stall.sum", 32'(sum_o), 32'd15);
        end

        // Exhaustive operand sweep through each port.
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 4096; n++) begin
                vec_t v;
                logic [11:0] nb;
                nb = 12'(n);
                v = mk(p == 0, nb[3:0], nb[7:4], nb[11:8], p == 1, nb[3:0], nb[7:4], nb[11:8],
                       1'b1, p == 0, p == 1);
                apply_vec(v, p == 0 ? "sweep0" : "sweep1");
            end
        end
        for (int i = 0; i < 3; i++)
            apply_vec(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0),
                      "drain");
        check("drained", 32'(q.size()), 32'd0);

        // Async reset while full: output must clear before the next edge.
        apply_vec(mk(1'b1, 4'd3, 4'd5, 4'd7, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0),
                  "prefill");
        check("full.sum_v", 32'(sum_v_o), 32'd1);
        drive(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        #2;
        reset_n_i = 1'b0;
        #1;
        check("midreset.sum_v", 32'(sum_v_o), 32'd0);
        check("midreset.sum", 32'(sum_o), 32'd0);
        q.delete();
        #3;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        apply_vec(mk(1'b1, 4'd1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0),
                  "postreset0");
        apply_vec(mk(1'b1, 4'd1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1),
                  "postreset1");
        for (int i = 0; i < 3; i++)
            apply_vec(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0),
                      "drain2");
        check("drained2", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one three-operand adder datapath between two requesters.
- Each requester presents operands a, b and c with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle; the exact sum is captured in a one-entry output register, tagged with the requester id, and drained through a valid/ready handshake.
- Sits between operand producers and a sum consumer; it is the scheduling front-end for the team's adder.

Parameters:
- width_p, default 4: operand width in bits for each of a, b and c.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  reset, asynchronous and active-low.
- req0_v_i  input  1  requester 0 operands valid.
- req0_a_i / req0_b_i / req0_c_i  input  width_p each  requester 0 operands.
- req0_ready_o  output  1  requester 0 operands accepted this cycle when high together with req0_v_i.
- req1_v_i  input  1  requester 1 operands valid.
- req1_a_i / req1_b_i / req1_c_i  input  width_p each  requester 1 operands.
- req1_ready_o  output  1  requester 1 handshake.
- sum_v_o  output  1  output register holds a valid sum.
- sum_o  output  width_p+2  exact sum a+b+c of the accepted request.
- sum_id_o  output  1  id of the requester that produced sum_o.
- sum_ready_i  input  1  consumer accepts sum_o when high together with sum_v_o.

Behaviour:
- Reset (reset_n_i low, takes effect immediately, no clock needed):
  - sum_v_o=0, sum_o=0, sum_id_o=0.
  - last_grant register=1, so requester 0 wins the first contention.
  - Output FSM state=EMPTY.
- Arithmetic:
  - Operands are zero-extended to width_p+2 and summed; there is no truncation or overflow.
  - Maximum result is 3*(2^width_p-1), which is 45 for width_p=4.
- Output FSM states:
  - EMPTY: sum_v_o=0.
  - FULL: sum_v_o=1.
- Capacity: can_accept = EMPTY, or (FULL and sum_ready_i). A drain and a new accept in the same cycle is supported, giving one result per cycle sustained.
- Grant, combinational, evaluated each cycle:
  - Only req0_v_i high: grant 0.
  - Only req1_v_i high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - Neither high: no grant.
- Ready outputs:
  - reqN_ready_o = (grant==N) and can_accept.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Transfer:
  - On reqN_v_i and reqN_ready_o, the register loads sum_o=a+b+c and sum_id_o=N, the state becomes FULL, and last_grant becomes N.
  - Latency is one cycle: the sum is visible on the edge after acceptance.
- Drain:
  - On sum_v_o and sum_ready_i with no new accept, the state becomes EMPTY.
  - sum_o and sum_id_o hold their last values; they are don't-care for checking while sum_v_o=0.
- Stall: FULL with sum_ready_i=0 drives both readies low. sum_o and sum_id_o stay stable until accepted.
- Fairness: last_grant updates only on an accepted transfer, so a stalled grant is not lost. With both valid continuously, grants alternate strictly 0,1,0,1.
- Requester contract: a requester with valid high and no ready must hold its operands stable.
- Reset mid-operation: any held sum is discarded with sum_v_o low immediately, and last_grant returns to 1.
- No combinational path from sum_ready_i to sum_o. The only combinational paths are sum_ready_i and valids to the readies.

Test Plan:
- Reset then single request: req0 a=3 b=5 c=7 held valid with sum_ready_i=1 -> req0_ready_o=1 that cycle; next cycle sum_v_o=1, sum_o=15, sum_id_o=0.
- Maximum values with width_p=4: req1 a=b=c=15 -> sum_o=45 (6'b101101), sum_id_o=1, no truncation.
- Contention: both requesters valid for 4 cycles with sum_ready_i=1 -> grants 0,1,0,1; sum_id_o sequence 0,1,0,1; one sum per cycle.
- Backpressure: sum_ready_i=0 while FULL with sum 15, req1 valid -> both readies 0 and sum_o stays 15 for 3 cycles. sum_ready_i rises -> same cycle req1_ready_o=1, next sum from req1.
- Exhaustive: all 4096 a/b/c combinations through each requester -> every sum_o equals the reference a+b+c and sum_id_o matches the issuing port.
- Async reset while FULL, asserted mid-cycle -> sum_v_o=0 before the next edge. After release, a contention grants requester 0 first.
